// File: rtl/ramb4_rd_pkg.sv
// Shared types and defaults for the RAMB4 read-side stream engine.
package ramb4_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 1;

  // A length must hold 0..2**addr_w inclusive, so it needs one bit more than an address.
  function automatic int len_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ramb4_rd_skid.sv
// Two-entry synchronous FIFO that absorbs RAM read data ahead of a valid/ready consumer.
module ramb4_rd_skid #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Empty buffer presents zero so the stream output is clean outside of valid words.
  assign valid = (count != 2'd0);
  assign dout  = valid ? mem[rd_ptr] : '0;
  assign occ   = count;

endmodule

// File: rtl/ramb4_stream_reader.sv
// Walks LEN addresses of a RAMB4 read port from BASE and streams the words out with valid/ready,
// hiding the one-cycle synchronous read latency behind a credit-checked two-entry buffer.
module ramb4_stream_reader
  import ramb4_rd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_RST,
  input  logic [DATA_W-1:0] RAM_DO,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY
);

  localparam int LEN_W = len_w(ADDR_W);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;
  logic              done_q;
  logic              issue;
  logic              credit_ok;
  logic              pop;
  logic              last_pop;
  logic              accept;
  logic [1:0]        occ;

  assign pop    = DOUT_VALID && DOUT_READY;
  assign accept = (state == IDLE) && START;

  // Words already buffered plus the one on its way must leave room after this cycle's pop.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  // All addresses have issued once in DRAIN, so a lone buffered word with nothing in flight is the last.
  assign last_pop = (state == DRAIN) && pop && (occ == 2'd1) && !inflight;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (START && (LEN != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        issue = credit_ok;
        if (issue && (remaining == LEN_W'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= last_pop || (accept && (LEN == '0));
      if (accept) begin
        addr      <= BASE;
        remaining <= LEN;
      end else if (issue) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  ramb4_rd_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk  (CLK),
    .rst  (RST),
    .push (inflight),
    .din  (RAM_DO),
    .pop  (pop),
    .dout (DOUT),
    .valid(DOUT_VALID),
    .occ  (occ)
  );

  assign BUSY     = (state != IDLE);
  assign DONE     = done_q;
  assign RAM_ADDR = addr;
  assign RAM_EN   = issue;
  assign RAM_WE   = 1'b0;
  assign RAM_RST  = 1'b0;

endmodule
